// File: rtl/note_player.sv
// Note player: latches a note and duration, looks up its phase step, counts beats,
// and answers codec sample requests three cycles later from a 64-point sine reader.

// Synchronous 64x20 step ROM. Twelve semitone steps for the top octave; lower
// octaves are the same steps shifted right. Note 0 (rest) reads as zero.
module frequency_rom (
  input  logic        i_clk,
  input  logic [5:0]  i_addr,
  output logic [19:0] o_step
);
  logic [5:0]  w_idx;
  logic [3:0]  w_semi;
  logic [2:0]  w_oct;
  logic [19:0] w_base;

  assign w_idx  = i_addr - 6'd1;
  assign w_semi = 4'(w_idx % 6'd12);
  assign w_oct  = 3'(w_idx / 6'd12);

  // round(65536 * 2^(k/12))
  always_comb begin
    w_base = 20'd0;
    case (w_semi)
      4'd0:  w_base = 20'd65536;
      4'd1:  w_base = 20'd69433;
      4'd2:  w_base = 20'd73562;
      4'd3:  w_base = 20'd77936;
      4'd4:  w_base = 20'd82570;
      4'd5:  w_base = 20'd87480;
      4'd6:  w_base = 20'd92682;
      4'd7:  w_base = 20'd98193;
      4'd8:  w_base = 20'd104032;
      4'd9:  w_base = 20'd110218;
      4'd10: w_base = 20'd116772;
      4'd11: w_base = 20'd123715;
      default: w_base = 20'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    o_step <= (i_addr == 6'd0) ? 20'd0 : (w_base >> (3'd5 - w_oct));
  end
endmodule

// Phase accumulator plus quarter-wave sine ROM. A request samples the current
// phase, then advances it; the sample is valid two cycles after the request.
module sine_reader (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_generate_next,
  input  logic [19:0] i_step_size,
  output logic [15:0] o_sample
);
  logic [19:0] r_phase;
  logic [5:0]  r_addr;
  logic [3:0]  w_pos;
  logic [4:0]  w_qidx;
  logic [15:0] w_mag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= 20'd0;
      r_addr  <= 6'd0;
    end else if (i_generate_next) begin
      r_addr  <= r_phase[19:14];
      r_phase <= r_phase + i_step_size;
    end
  end

  assign w_pos  = r_addr[3:0];
  assign w_qidx = r_addr[4] ? (5'd16 - {1'b0, w_pos}) : {1'b0, w_pos};

  // round(32767 * sin(2*pi*k/64)), k = 0..16
  always_comb begin
    w_mag = 16'd0;
    case (w_qidx)
      5'd1:  w_mag = 16'd3212;
      5'd2:  w_mag = 16'd6393;
      5'd3:  w_mag = 16'd9512;
      5'd4:  w_mag = 16'd12539;
      5'd5:  w_mag = 16'd15446;
      5'd6:  w_mag = 16'd18204;
      5'd7:  w_mag = 16'd20787;
      5'd8:  w_mag = 16'd23170;
      5'd9:  w_mag = 16'd25329;
      5'd10: w_mag = 16'd27245;
      5'd11: w_mag = 16'd28898;
      5'd12: w_mag = 16'd30273;
      5'd13: w_mag = 16'd31356;
      5'd14: w_mag = 16'd32137;
      5'd15: w_mag = 16'd32609;
      5'd16: w_mag = 16'd32767;
      default: w_mag = 16'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) o_sample <= 16'd0;
    else         o_sample <= r_addr[5] ? -w_mag : w_mag;
  end
endmodule

module note_player (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_play_enable,
  input  logic [5:0]  i_note_to_load,
  input  logic [5:0]  i_duration_to_load,
  input  logic        i_load_new_note,
  input  logic        i_beat,
  input  logic        i_generate_next_sample,
  output logic [15:0] o_sample_out,
  output logic        o_new_sample_ready,
  output logic        o_done_with_note
);
  logic [5:0]  r_note;
  logic [5:0]  r_dur;
  logic [19:0] r_step;
  logic        r_req_d1, r_req_d2, r_req_d3;
  logic [15:0] r_sample;
  logic        r_done;
  logic        w_active;
  logic        w_reader_reset;
  logic        w_reader_gen;
  logic [19:0] w_rom_step;
  logic [15:0] w_reader_sample;

  assign w_active       = (r_dur != 6'd0) && (r_note != 6'd0);
  assign w_reader_reset = i_reset || i_load_new_note;
  assign w_reader_gen   = i_generate_next_sample && i_play_enable && w_active;

  frequency_rom u_rom (
    .i_clk  (i_clk),
    .i_addr (r_note),
    .o_step (w_rom_step)
  );

  sine_reader u_reader (
    .i_clk           (i_clk),
    .i_reset         (w_reader_reset),
    .i_generate_next (w_reader_gen),
    .i_step_size     (r_step),
    .o_sample        (w_reader_sample)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_note   <= 6'd0;
      r_dur    <= 6'd0;
      r_step   <= 20'd0;
      r_req_d1 <= 1'b0;
      r_req_d2 <= 1'b0;
      r_req_d3 <= 1'b0;
      r_sample <= 16'd0;
      r_done   <= 1'b0;
    end else begin
      r_step   <= w_rom_step;
      r_req_d1 <= i_generate_next_sample && i_play_enable;
      r_req_d2 <= r_req_d1;
      r_req_d3 <= r_req_d2;
      // Sample register loads as the request enters req_d3, so it is valid with the strobe.
      if (r_req_d2) r_sample <= w_active ? w_reader_sample : 16'h0000;
      r_done <= 1'b0;
      if (i_load_new_note) begin
        r_note <= i_note_to_load;
        r_dur  <= i_duration_to_load;
        r_done <= (i_duration_to_load == 6'd0);
      end else if (i_beat && i_play_enable && r_dur != 6'd0) begin
        r_dur  <= r_dur - 6'd1;
        r_done <= (r_dur == 6'd1);
      end
    end
  end

  assign o_sample_out       = r_sample;
  assign o_new_sample_ready = r_req_d3;
  assign o_done_with_note   = r_done;
endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed and random stimulus compared cycle by cycle
// against a transaction-level model built from the note/beat/request rules.
module tb_note_player;
  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst, play, ld, bt, rq;
  logic [5:0]  nt, du;
  logic [15:0] sample_out;
  logic        nsr, done;

  note_player dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_play_enable          (play),
    .i_note_to_load         (nt),
    .i_duration_to_load     (du),
    .i_load_new_note        (ld),
    .i_beat                 (bt),
    .i_generate_next_sample (rq),
    .o_sample_out           (sample_out),
    .o_new_sample_ready     (nsr),
    .o_done_with_note       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          phase;
    logic [15:0] val;
  } req_t;

  req_t        pq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_cyc    = 0;
  int          m_note   = 0;
  int          m_dur    = 0;
  int          m_phase  = 0;
  logic        m_done   = 1'b0;
  logic        m_nsr    = 1'b0;
  logic [15:0] m_sample = 16'd0;

  function automatic int step_of(input int n);
    int k, o;
    if (n == 0) return 0;
    k = (n - 1) % 12;
    o = (n - 1) / 12;
    return $rtoi(65536.0 * $pow(2.0, real'(k) / 12.0) + 0.5) >> (5 - o);
  endfunction

  function automatic logic [15:0] sine_of(input int ph);
    real v;
    int  r;
    v = 32767.0 * $sin(2.0 * PI * real'(ph >> 14) / 64.0);
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return 16'(r);
  endfunction

  // One clock: drive inputs, update the model, then check all outputs after the edge.
  task automatic step(input bit l, input int n, input int d, input bit b, input bit r);
    bit act, acc, nd;
    ld = l; nt = 6'(n); du = 6'(d); bt = b; rq = r;
    act = (m_dur != 0) && (m_note != 0);
    if (rst) begin
      pq.delete();
      m_note = 0; m_dur = 0; m_phase = 0;
      m_done = 1'b0; m_nsr = 1'b0; m_sample = 16'd0;
    end else begin
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].due == m_cyc + 1) pq[i].val = act ? sine_of(pq[i].phase) : 16'd0;
      acc = r && play;
      if (acc) begin
        pq.push_back('{due: m_cyc + 3, phase: (l ? 0 : m_phase), val: 16'd0});
        if (!l && act) m_phase = (m_phase + step_of(m_note)) & 20'hFFFFF;
      end
      nd = 1'b0;
      if (l) begin
        m_note = n; m_dur = d; m_phase = 0; nd = (d == 0);
      end else if (b && play && m_dur > 0) begin
        m_dur--; nd = (m_dur == 0);
      end
      m_done = nd;
      m_nsr  = 1'b0;
      if (pq.size() > 0 && pq[0].due == m_cyc + 1) begin
        m_nsr = 1'b1;
        m_sample = pq[0].val;
        void'(pq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    m_cyc++;
    n_assert++;
    assert (nsr === m_nsr) else begin
      n_fail++; $error("FAIL new_sample_ready cyc=%0d got=%b exp=%b", m_cyc, nsr, m_nsr);
    end
    n_assert++;
    assert (done === m_done) else begin
      n_fail++; $error("FAIL done_with_note cyc=%0d got=%b exp=%b", m_cyc, done, m_done);
    end
    n_assert++;
    assert (sample_out === m_sample) else begin
      n_fail++; $error("FAIL sample_out cyc=%0d got=%h exp=%h", m_cyc, sample_out, m_sample);
    end
  endtask

  task automatic cycles(input int n, input int rq_every, input int bt_every);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, (bt_every > 0) && (i % bt_every == bt_every - 1),
           (rq_every > 0) && (i % rq_every == 0));
  endtask

  task automatic load(input int n, input int d);
    step(1, n, d, 0, 0);
    cycles(3, 0, 0);
  endtask

  initial begin
    int rq_gap, len, n, d;
    rst = 1'b1; play = 1'b1; ld = 0; bt = 0; rq = 0; nt = 0; du = 0;

    // Reset with requests pending, then quiet
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    rst = 1'b0;
    cycles(6, 0, 0);

    // Basic tone, note 40, then 3 beats to expiry and zero answers afterwards
    load(40, 3);
    cycles(40, 8, 0);
    cycles(36, 8, 12);
    cycles(24, 8, 0);

    // Rest with duration 2, and duration 0
    cycles(4, 0, 0);
    load(0, 2);
    cycles(30, 6, 10);
    cycles(4, 0, 0);
    load(5, 0);
    cycles(10, 4, 0);

    // Pause mid-note with beats and requests; one request in flight at pause
    cycles(4, 0, 0);
    load(25, 4);
    cycles(20, 5, 0);
    step(0, 0, 0, 0, 1);
    play = 1'b0;
    cycles(20, 3, 4);
    play = 1'b1;
    cycles(50, 5, 10);

    // Load + beat + request in one cycle while old note has one beat left
    cycles(4, 0, 0);
    load(30, 1);
    cycles(10, 5, 0);
    cycles(4, 0, 0);
    step(1, 7, 5, 1, 1);
    cycles(3, 0, 0);
    cycles(60, 6, 10);

    // Reset mid-note aborts without a done pulse
    cycles(4, 0, 0);
    load(12, 3);
    cycles(6, 3, 0);
    step(0, 0, 0, 0, 1);
    rst = 1'b1;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    rst = 1'b0;
    cycles(10, 4, 5);

    // Random notes, durations, beats, requests and pauses
    for (int it = 0; it < 30; it++) begin
      cycles(4, 0, 0);
      n = (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, 63));
      d = int'($urandom_range(0, 4));
      load(n, d);
      len = int'($urandom_range(30, 90));
      rq_gap = 0;
      for (int c = 0; c < len; c++) begin
        if (($urandom % 40) == 0) play = ~play;
        step(0, 0, 0, ($urandom % 8) == 0, rq_gap == 0);
        rq_gap = (rq_gap == 0) ? int'($urandom_range(1, 7)) : rq_gap - 1;
      end
      play = 1'b1;
    end
    cycles(6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
